// File: rtl/hazard_controller_if.sv
// RF-stage instruction descriptor and hazard-control results exchanged between
// the pipeline datapath (master) and the hazard controller (slave).
interface hazard_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rf_Rn;
  logic [REG_W-1:0] rf_Rm;
  logic             rf_useA;
  logic             rf_useB;
  logic [REG_W-1:0] rf_Rd;
  logic             rf_RegWrite;
  logic             rf_load;
  logic             rf_setFlag;
  logic             rf_condBr;
  logic             pc_wrEn;
  logic             ex_bubble;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             flagFwd;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rf_Rn, rf_Rm, rf_useA, rf_useB, rf_Rd, rf_RegWrite, rf_load,
           rf_setFlag, rf_condBr,
    input  pc_wrEn, ex_bubble, fwdA, fwdB, flagFwd, stall_count
  );

  modport slave (
    input  rf_Rn, rf_Rm, rf_useA, rf_useB, rf_Rd, rf_RegWrite, rf_load,
           rf_setFlag, rf_condBr,
    output pc_wrEn, ex_bubble, fwdA, fwdB, flagFwd, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Load-use stall, operand forwarding and flag forwarding for the RF-stage
// instruction of the 5-stage pipeline, from the EX/MEM/WB destination records.
module hazard_controller #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_controller_if.slave hz
);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
    logic             set_flag;
  } stage_rec_t;

  localparam logic [REG_W-1:0] XZR = {REG_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // index 0 = EX, 1 = MEM, 2 = WB
  stage_rec_t       stage_r [3];
  logic [CNT_W-1:0] stall_count_r;
  logic             stall_s;
  logic [1:0]       fwda_s;
  logic [1:0]       fwdb_s;
  logic             flag_fwd_s;
  stage_rec_t       rf_rec_s;

  function automatic logic reg_match(input stage_rec_t rec, input logic [REG_W-1:0] src);
    return rec.wr && (rec.rd == src) && (src != XZR);
  endfunction

  // EX wins over MEM; an EX-stage load has no data yet and is covered by the stall
  function automatic logic [1:0] fwd_sel(input stage_rec_t ex, input stage_rec_t mem,
                                         input logic use_src, input logic [REG_W-1:0] src);
    logic [1:0] sel;
    if (use_src && reg_match(ex, src) && !ex.load) begin
      sel = 2'b01;
    end else if (use_src && reg_match(mem, src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard decisions for the instruction currently in RF
  always_comb begin
    stall_s    = 1'b0;
    fwda_s     = 2'b00;
    fwdb_s     = 2'b00;
    flag_fwd_s = 1'b0;
    rf_rec_s   = '0;
    if (stage_r[0].load &&
        ((hz.rf_useA && reg_match(stage_r[0], hz.rf_Rn)) ||
         (hz.rf_useB && reg_match(stage_r[0], hz.rf_Rm)))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    fwda_s     = fwd_sel(stage_r[0], stage_r[1], hz.rf_useA, hz.rf_Rn);
    fwdb_s     = fwd_sel(stage_r[0], stage_r[1], hz.rf_useB, hz.rf_Rm);
    flag_fwd_s = hz.rf_condBr && stage_r[0].set_flag && !stall_s;
    if (stall_s) begin
      rf_rec_s = '0;
    end else begin
      rf_rec_s = '{rd: hz.rf_Rd, wr: hz.rf_RegWrite, load: hz.rf_load,
                   set_flag: hz.rf_setFlag};
    end
  end

  // Stage records advance every cycle; a stall injects an empty record into EX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_r[0] <= '0;
      stage_r[1] <= '0;
      stage_r[2] <= '0;
    end else begin
      stage_r[2] <= stage_r[1];
      stage_r[1] <= stage_r[0];
      stage_r[0] <= rf_rec_s;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_r <= '0;
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign hz.pc_wrEn     = ~stall_s;
  assign hz.ex_bubble   = stall_s;
  assign hz.fwdA        = fwda_s;
  assign hz.fwdB        = fwdb_s;
  assign hz.flagFwd     = flag_fwd_s;
  assign hz.stall_count = stall_count_r;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage CPU (IF, RF, EX, MEM, WB).
- Tracks destination-register and control state of the instructions in EX, MEM and WB.
- Generates, for the RF-stage instruction:
  - load-use stalls and bubbles,
  - operand forwarding selects,
  - flag forwarding for conditional branches.
- Sits beside the IF/RF pipeline register and drives its write enable plus the EX-stage operand muxes.

Parameters:
- REG_W, 5, register address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rf_Rn  in  REG_W  RF-stage first source register.
- rf_Rm  in  REG_W  RF-stage second source register (Rm or Rd, already muxed by Reg2Loc).
- rf_useA  in  1  RF instruction reads rf_Rn.
- rf_useB  in  1  RF instruction reads rf_Rm.
- rf_Rd  in  REG_W  RF-stage destination.
- rf_RegWrite  in  1  RF instruction writes rf_Rd.
- rf_load  in  1  RF instruction is LDUR/LDURB.
- rf_setFlag  in  1  RF instruction sets flags.
- rf_condBr  in  1  RF instruction is B.cond and needs flags.
- pc_wrEn  out  1  PC and IF/RF register write enable; 0 = hold.
- ex_bubble  out  1  EX-stage controls are forced to a NOP this cycle.
- fwdA  out  2  operand A select: 00 regfile, 01 EX result, 10 MEM result.
- fwdB  out  2  operand B select, same encoding as fwdA.
- flagFwd  out  1  1 = branch uses live ALU flags from EX; 0 = flag register.
- stall_count  out  CNT_W  number of stall cycles since reset.

Behaviour:
- Internal state consists of three stage records (EX, MEM, WB). Each record holds Rd, RegWrite, load and setFlag. An asynchronous reset clears every field to 0.
- Stage record update, every posedge clk:
  - WB takes the old MEM record.
  - MEM takes the old EX record.
  - EX takes the RF inputs, or all zeros when stall is 1.
- Register 31 (XZR) is never a hazard. Any match where the compared register is 31 is ignored.
- Matching rule: matchX(stage) = stage.RegWrite and stage.Rd == src and src != 31, evaluated for src = rf_Rn and src = rf_Rm.
- Load-use stall (combinational): stall = 1 when the EX record has load = 1 and either:
  - (rf_useA and matchX(EX, rf_Rn)), or
  - (rf_useB and matchX(EX, rf_Rm)).
- Stall effects:
  - pc_wrEn = ~stall and ex_bubble = stall.
  - The RF instruction is held exactly one cycle. On the next cycle the load is in MEM and normal forwarding applies.
- Forwarding for operand A (combinational, EX has priority over MEM):
  - If rf_useA and matchX(EX, rf_Rn) and not EX.load, then fwdA = 01.
  - Else if rf_useA and matchX(MEM, rf_Rn), then fwdA = 10. This includes a MEM-stage load, whose data is valid at the end of MEM.
  - Else fwdA = 00.
  - The WB stage needs no forwarding; the regfile writes on negedge and reads in the same cycle.
- Forwarding for operand B: identical to operand A, using rf_Rm and rf_useB.
- During a stall, fwdA and fwdB may hold any value; ex_bubble makes them irrelevant.
- Flag forwarding: flagFwd = rf_condBr and EX.setFlag and not stall. A B.cond immediately after ADDS/SUBS therefore takes the ALU flags combinationally. Otherwise it uses the registered flags.
- stall_count:
  - Resets to 0.
  - Increments on each posedge where stall = 1.
  - Saturates at all-ones and never wraps.
- Reset values of outputs:
  - pc_wrEn = 1, ex_bubble = 0, fwdA = fwdB = 00, flagFwd = 0, stall_count = 0.
  - These follow because all stage records are cleared.
- Reset asserted mid-operation immediately clears all records and the counter. It has no synchronous release dependency.
- Simultaneous events:
  - A stall and a MEM-match on the other operand can occur together. The stall wins; forwarding is re-evaluated on the held cycle.
  - A back-to-back load followed by a dependent load also stalls once.

Test Plan:
- Reset low for 2 cycles -> pc_wrEn = 1, ex_bubble = 0, fwdA = fwdB = 00, flagFwd = 0, stall_count = 0; after release, records stay empty.
- ADDI X1 then ADD X2,X1,X3 (rf_Rn = 1, rf_useA = 1) -> fwdA = 01, fwdB = 00, no stall. One cycle later, with an unrelated instruction in between, a consumer of X1 -> fwdA = 10.
- LDUR X4 then SUB X5,X6,X4 (rf_Rm = 4, rf_useB = 1):
  - First cycle: pc_wrEn = 0, ex_bubble = 1, stall_count 0 -> 1.
  - Next cycle: pc_wrEn = 1, fwdB = 10.
- Writer of X31 followed by a reader of X31 -> fwdA = fwdB = 00 and no stall, including when the writer is a load.
- ADDS X7 then B.cond (rf_condBr = 1) -> flagFwd = 1. With a NOP inserted between them -> flagFwd = 0.
- Force 2^CNT_W + 3 load-use stalls -> stall_count holds at all-ones. Then assert reset mid-stall -> stall_count = 0 and pc_wrEn = 1 within the same cycle, asynchronously.
